// File: rtl/mips_data_mem_if.sv
// rtl/mips_data_mem_if.sv - MEM-stage data memory bus between datapath and memory
interface mips_data_mem_if;
  logic [31:0] mem_address;
  logic [31:0] write_data;
  logic        sig_mem_read;
  logic        sig_mem_write;
  logic [31:0] read_data;
  logic        sig_addr_err;

  modport master (
    output mem_address, write_data, sig_mem_read, sig_mem_write,
    input  read_data, sig_addr_err
  );

  modport slave (
    input  mem_address, write_data, sig_mem_read, sig_mem_write,
    output read_data, sig_addr_err
  );
endinterface

// File: rtl/mips_data_mem.sv
// rtl/mips_data_mem.sv - word-organised data memory, combinational read, clocked write
module mips_data_mem #(
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_data_mem_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic          legal;
  logic [AW-1:0] index;

  // Upper bits must be zero: out-of-range addresses fault rather than wrap.
  assign legal = (bus.mem_address[1:0] == 2'b00) &&
                 (bus.mem_address[31:AW+2] == '0);
  assign index = bus.mem_address[AW+1:2];

  assign bus.sig_addr_err = (bus.sig_mem_read | bus.sig_mem_write) & ~legal;
  assign bus.read_data    = (bus.sig_mem_read && legal && rst_n) ? mem_q[index] : 32'h0;

  always_comb begin
    mem_d = mem_q;
    if (bus.sig_mem_write && legal) begin
      mem_d[index] = bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_mips_data_mem.sv
// tb/tb_mips_data_mem.sv - directed self-checking bench for mips_data_mem
module tb_mips_data_mem;

  localparam int DEPTH = 256;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  mips_data_mem_if bus_if ();

  mips_data_mem #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rd, input logic wr);
    bus_if.mem_address   = addr;
    bus_if.write_data    = wdata;
    bus_if.sig_mem_read  = rd;
    bus_if.sig_mem_write = wr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(32'd0, 32'h0, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.read_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_rd0: got %h want %h", bus_if.read_data, 32'h0);
    end
    vec_cnt++;
    if (bus_if.sig_addr_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_err0: got %b want 0", bus_if.sig_addr_err);
    end
    drive(32'd4, 32'h0, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.read_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_rd4: got %h want %h", bus_if.read_data, 32'h0);
    end
    drive(32'd6, 32'h0, 1'b0, 1'b0);
    vec_cnt++;
    if (bus_if.sig_addr_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_err: got %b want 0", bus_if.sig_addr_err);
    end
  endtask

  task automatic test_write_read();
    drive(32'd4, 32'd12, 1'b0, 1'b1);
    tick();
    drive(32'd4, 32'h0, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.read_data !== 32'd12) begin
      err_cnt++;
      $display("FAIL wr_rd4: got %h want %h", bus_if.read_data, 32'd12);
    end
    drive(32'd8, 32'h0, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.read_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL alias_rd8: got %h want %h", bus_if.read_data, 32'h0);
    end
  endtask

  task automatic test_read_disable();
    drive(32'd12, 32'd955, 1'b0, 1'b1);
    tick();
    drive(32'd12, 32'h0, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.read_data !== 32'd955) begin
      err_cnt++;
      $display("FAIL wr_rd12: got %h want %h", bus_if.read_data, 32'd955);
    end
    drive(32'd12, 32'h0, 1'b0, 1'b0);
    vec_cnt++;
    if (bus_if.read_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL rd_off: got %h want %h", bus_if.read_data, 32'h0);
    end
  endtask

  task automatic test_addr_err();
    drive(32'd6, 32'd7, 1'b0, 1'b1);
    vec_cnt++;
    if (bus_if.sig_addr_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL misalign_err: got %b want 1", bus_if.sig_addr_err);
    end
    tick();
    drive(32'd4, 32'h0, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.read_data !== 32'd12) begin
      err_cnt++;
      $display("FAIL misalign_keep: got %h want %h", bus_if.read_data, 32'd12);
    end
    drive(32'd6, 32'h0, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.read_data !== 32'h0 || bus_if.sig_addr_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL misalign_rd: got %h/%b want %h/1",
               bus_if.read_data, bus_if.sig_addr_err, 32'h0);
    end
    drive(32'(4 * DEPTH), 32'h0BAD_0BAD, 1'b0, 1'b1);
    vec_cnt++;
    if (bus_if.sig_addr_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL range_err: got %b want 1", bus_if.sig_addr_err);
    end
    tick();
    drive(32'd0, 32'h0, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.read_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL range_nowrap: got %h want %h", bus_if.read_data, 32'h0);
    end
    drive(32'(4 * DEPTH - 4), 32'h0, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.sig_addr_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL top_word_err: got %b want 0", bus_if.sig_addr_err);
    end
  endtask

  task automatic test_rw_same();
    drive(32'd16, 32'hDEAD_BEEF, 1'b1, 1'b1);
    vec_cnt++;
    if (bus_if.read_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL rw_old: got %h want %h", bus_if.read_data, 32'h0);
    end
    tick();
    drive(32'd16, 32'h0, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.read_data !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL rw_new: got %h want %h", bus_if.read_data, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    addrs = '{32'd20, 32'd24, 32'd1020};
    datas = '{32'h1111_0001, 32'h2222_0002, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      drive(addrs[i], datas[i], 1'b0, 1'b1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(addrs[i], 32'h0, 1'b1, 1'b0);
      vec_cnt++;
      if (bus_if.read_data !== datas[i]) begin
        err_cnt++;
        $display("FAIL b2b_rd%0d: got %h want %h", addrs[i], bus_if.read_data, datas[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] addrs [6];
    addrs = '{32'd4, 32'd12, 32'd16, 32'd20, 32'd24, 32'd1020};
    drive(32'd4, 32'h5555_AAAA, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus_if.read_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL rst_rd: got %h want %h", bus_if.read_data, 32'h0);
    end
    drive(32'd5, 32'h5555_AAAA, 1'b1, 1'b0);
    vec_cnt++;
    if (bus_if.sig_addr_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_err: got %b want 1", bus_if.sig_addr_err);
    end
    drive(32'd4, 32'h5555_AAAA, 1'b1, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(addrs[i], 32'h0, 1'b1, 1'b0);
      vec_cnt++;
      if (bus_if.read_data !== 32'h0) begin
        err_cnt++;
        $display("FAIL post_rst_rd%0d: got %h want %h", addrs[i], bus_if.read_data, 32'h0);
      end
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    drive(32'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_read_disable();
    test_addr_err();
    test_rw_same();
    test_back_to_back();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
